// File: rtl/pe_dot_ctrl.sv
// pe_dot_ctrl: sequences 512-bit neuron/weight chunks from the PE SRAMs into the
// 32-lane int16 multiplier, reduces each chunk's lane products and accumulates a
// signed dot product, then pulses done.
module pe_dot_ctrl #(
  parameter int ADDR_W = 8,
  parameter int ACC_W  = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] vec_len,
  input  logic [ADDR_W-1:0] neuron_base,
  input  logic [ADDR_W-1:0] weight_base,
  output logic              busy,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] neuron_addr,
  output logic [ADDR_W-1:0] weight_addr,
  input  logic [511:0]      neuron_rdata,
  input  logic [511:0]      weight_rdata,
  output logic [511:0]      mult_neuron,
  output logic [511:0]      mult_weight,
  input  logic [1023:0]     mult_result,
  output logic [ACC_W-1:0]  result,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   nbase_q, nbase_d;
  logic [ADDR_W-1:0]   wbase_q, wbase_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [1:0]          drain_q, drain_d;
  logic                acc_clear;

  logic                v1_q, v1_d;
  logic                v2_q, v2_d;
  logic                v3_q, v3_d;
  logic [511:0]        mult_neuron_q, mult_neuron_d;
  logic [511:0]        mult_weight_q, mult_weight_d;
  logic [36:0]         sum_q, sum_d;
  logic [36:0]         lane_sum;
  logic [ACC_W-1:0]    acc_q, acc_d;

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign sram_rd_en  = (state_q == RUN);
  assign neuron_addr = nbase_q + cnt_q;
  assign weight_addr = wbase_q + cnt_q;
  assign mult_neuron = mult_neuron_q;
  assign mult_weight = mult_weight_q;
  assign result      = acc_q;

  // Next-state logic: RUN issues one read per cycle, DRAIN lets the last chunk reach the accumulator.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    nbase_d   = nbase_q;
    wbase_d   = wbase_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    acc_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_clear = 1'b1;
          if (vec_len != '0) begin
            len_d   = vec_len;
            nbase_d = neuron_base;
            wbase_d = weight_base;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (cnt_q == len_q - ONE) begin
          drain_d = 2'd0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      DRAIN: begin
        if (drain_q == 2'd3) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: valid bits follow each chunk through operand load, lane reduction and accumulation.
  always_comb begin
    v1_d          = sram_rd_en;
    v2_d          = v1_q;
    v3_d          = v2_q;
    mult_neuron_d = v1_q ? neuron_rdata : mult_neuron_q;
    mult_weight_d = v1_q ? weight_rdata : mult_weight_q;
    lane_sum      = '0;
    for (int i = 0; i < 32; i++) begin
      lane_sum = lane_sum + {{5{mult_result[32*i+31]}}, mult_result[32*i +: 32]};
    end
    sum_d = v2_q ? lane_sum : sum_q;
    if (acc_clear) begin
      acc_d = '0;
    end else if (v3_q) begin
      acc_d = acc_q + ACC_W'($signed(sum_q));
    end else begin
      acc_d = acc_q;
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      len_q         <= '0;
      nbase_q       <= '0;
      wbase_q       <= '0;
      cnt_q         <= '0;
      drain_q       <= '0;
      v1_q          <= 1'b0;
      v2_q          <= 1'b0;
      v3_q          <= 1'b0;
      mult_neuron_q <= '0;
      mult_weight_q <= '0;
      sum_q         <= '0;
      acc_q         <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      nbase_q       <= nbase_d;
      wbase_q       <= wbase_d;
      cnt_q         <= cnt_d;
      drain_q       <= drain_d;
      v1_q          <= v1_d;
      v2_q          <= v2_d;
      v3_q          <= v3_d;
      mult_neuron_q <= mult_neuron_d;
      mult_weight_q <= mult_weight_d;
      sum_q         <= sum_d;
      acc_q         <= acc_d;
    end
  end

endmodule

// File: tb/tb_pe_dot_ctrl.sv
// tb_pe_dot_ctrl: directed checks of pe_dot_ctrl with a behavioural SRAM pair and multiplier.
module tb_pe_dot_ctrl;

  logic          clk;
  logic          rst;
  logic          start;
  logic [7:0]    vec_len;
  logic [7:0]    neuron_base;
  logic [7:0]    weight_base;
  logic          busy;
  logic          sram_rd_en;
  logic [7:0]    neuron_addr;
  logic [7:0]    weight_addr;
  logic [511:0]  neuron_rdata;
  logic [511:0]  weight_rdata;
  logic [511:0]  mult_neuron;
  logic [511:0]  mult_weight;
  logic [1023:0] mult_result;
  logic [47:0]   result;
  logic          done;

  logic [511:0]  nmem [256];
  logic [511:0]  wmem [256];
  logic [7:0]    nlog [16];
  logic [7:0]    wlog [16];

  int tests_run;
  int tests_failed;

  pe_dot_ctrl #(.ADDR_W(8), .ACC_W(48)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .vec_len      (vec_len),
    .neuron_base  (neuron_base),
    .weight_base  (weight_base),
    .busy         (busy),
    .sram_rd_en   (sram_rd_en),
    .neuron_addr  (neuron_addr),
    .weight_addr  (weight_addr),
    .neuron_rdata (neuron_rdata),
    .weight_rdata (weight_rdata),
    .mult_neuron  (mult_neuron),
    .mult_weight  (mult_weight),
    .mult_result  (mult_result),
    .result       (result),
    .done         (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-cycle read latency SRAM pair.
  always @(posedge clk) begin
    if (sram_rd_en) begin
      neuron_rdata <= nmem[neuron_addr];
      weight_rdata <= wmem[weight_addr];
    end
  end

  function automatic logic [31:0] mul16(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = 32'($signed(a));
    sb = 32'($signed(b));
    return sa * sb;
  endfunction

  // Combinational 32-lane signed multiplier array.
  always_comb begin
    mult_result = '0;
    for (int i = 0; i < 32; i++) begin
      mult_result[32*i +: 32] = mul16(mult_neuron[16*i +: 16], mult_weight[16*i +: 16]);
    end
  end

  task automatic fill(input bit is_w, input logic [7:0] a, input logic [15:0] v);
    logic [511:0] chunk;
    for (int i = 0; i < 32; i++) chunk[16*i +: 16] = v;
    if (is_w) wmem[a] = chunk;
    else nmem[a] = chunk;
  endtask

  // Drives start in cycle 0 (caller sits just after an edge) and observes cycles 1..max_c.
  task automatic run_dot(input int len, input logic [7:0] nb, input logic [7:0] wb,
                         input int hold, input int max_c,
                         output int done_c, output int n_done, output int n_rd, output int busy_c,
                         output logic [47:0] res_done, output logic [47:0] res_c1,
                         output logic [47:0] res_last);
    start       = 1'b1;
    vec_len     = 8'(len);
    neuron_base = nb;
    weight_base = wb;
    done_c   = -1;
    n_done   = 0;
    n_rd     = 0;
    busy_c   = 0;
    res_done = '0;
    res_c1   = '0;
    res_last = '0;
    for (int c = 1; c <= max_c; c++) begin
      @(posedge clk);
      #1;
      start = (c < hold);
      if (sram_rd_en) begin
        if (n_rd < 16) begin
          nlog[n_rd] = neuron_addr;
          wlog[n_rd] = weight_addr;
        end
        n_rd++;
      end
      if (busy) busy_c++;
      if (done) begin
        n_done++;
        if (done_c < 0) begin
          done_c   = c;
          res_done = result;
        end
      end
      if (c == 1) res_c1 = result;
      res_last = result;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    tests_run++;
    if ({busy, sram_rd_en, done} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: busy/rd_en/done=%b expected 000", {busy, sram_rd_en, done});
    end
    tests_run++;
    if (neuron_addr !== 8'h00 || weight_addr !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_addr: n=%h w=%h expected 00 00", neuron_addr, weight_addr);
    end
    tests_run++;
    if (mult_neuron !== '0 || mult_weight !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_operands: not zero");
    end
    tests_run++;
    if (result !== 48'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_result: got %h expected 0", result);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_chunk();
    int dc, nd, nr, bc;
    logic [47:0] rd, r1, rl;
    fill(1'b0, 8'h00, 16'h0001);
    fill(1'b1, 8'h00, 16'h0001);
    run_dot(1, 8'h00, 8'h00, 1, 8, dc, nd, nr, bc, rd, r1, rl);
    tests_run++;
    if (dc !== 6) begin
      tests_failed++;
      $display("[TB] FAIL single_done_cycle: got %0d expected 6", dc);
    end
    tests_run++;
    if (nd !== 1 || nr !== 1) begin
      tests_failed++;
      $display("[TB] FAIL single_counts: dones=%0d reads=%0d expected 1 1", nd, nr);
    end
    tests_run++;
    if (nlog[0] !== 8'h00 || wlog[0] !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL single_addr: n=%h w=%h expected 00 00", nlog[0], wlog[0]);
    end
    tests_run++;
    if (rd !== 48'd32) begin
      tests_failed++;
      $display("[TB] FAIL single_result: got %h expected 20", rd);
    end
    tests_run++;
    if (bc !== 6) begin
      tests_failed++;
      $display("[TB] FAIL single_busy: got %0d cycles expected 6", bc);
    end
  endtask

  task automatic test_lane_sum();
    int dc, nd, nr, bc;
    logic [47:0] rd, r1, rl;
    for (int i = 0; i < 32; i++) begin
      nmem[8'h30][16*i +: 16] = 16'(i);
      wmem[8'h31][16*i +: 16] = (i % 2 == 0) ? 16'h0001 : 16'hFFFF;
    end
    run_dot(1, 8'h30, 8'h31, 1, 8, dc, nd, nr, bc, rd, r1, rl);
    tests_run++;
    if (rd !== 48'hFFFF_FFFF_FFF0 || dc !== 6) begin
      tests_failed++;
      $display("[TB] FAIL lane_sum: got %h at cycle %0d expected FFFFFFFFFFF0 at 6", rd, dc);
    end
  endtask

  task automatic test_signed_multi();
    int dc, nd, nr, bc;
    logic [47:0] rd, r1, rl;
    for (int k = 0; k < 4; k++) begin
      fill(1'b0, 8'(8'h20 + k), 16'hFFFE);
      fill(1'b1, 8'(8'h20 + k), 16'h0003);
    end
    run_dot(4, 8'h20, 8'h20, 1, 12, dc, nd, nr, bc, rd, r1, rl);
    tests_run++;
    if (dc !== 9) begin
      tests_failed++;
      $display("[TB] FAIL signed_done_cycle: got %0d expected 9", dc);
    end
    tests_run++;
    if (rd !== 48'hFFFF_FFFF_FD00) begin
      tests_failed++;
      $display("[TB] FAIL signed_result: got %h expected FFFFFFFFFD00", rd);
    end
  endtask

  task automatic test_extreme();
    int dc, nd, nr, bc;
    logic [47:0] rd, r1, rl;
    for (int k = 0; k < 8; k++) begin
      fill(1'b0, 8'(8'h40 + k), 16'h8000);
      fill(1'b1, 8'(8'h80 + k), 16'h8000);
    end
    run_dot(8, 8'h40, 8'h80, 1, 16, dc, nd, nr, bc, rd, r1, rl);
    tests_run++;
    if (rd !== 48'h0040_0000_0000 || dc !== 13) begin
      tests_failed++;
      $display("[TB] FAIL extreme_result: got %h at cycle %0d expected 004000000000 at 13", rd, dc);
    end
  endtask

  task automatic test_addr_wrap();
    int dc, nd, nr, bc;
    logic [47:0] rd, r1, rl;
    logic [7:0] exp_n [4];
    exp_n = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    for (int k = 0; k < 4; k++) begin
      fill(1'b0, exp_n[k], 16'(k + 1));
      fill(1'b1, 8'(8'h10 + k), 16'h0001);
    end
    run_dot(4, 8'hFE, 8'h10, 1, 12, dc, nd, nr, bc, rd, r1, rl);
    tests_run++;
    if (nr !== 4) begin
      tests_failed++;
      $display("[TB] FAIL wrap_reads: got %0d expected 4", nr);
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (nlog[k] !== exp_n[k] || wlog[k] !== 8'(8'h10 + k)) begin
        tests_failed++;
        $display("[TB] FAIL wrap_addr%0d: n=%h w=%h expected %h %h", k, nlog[k], wlog[k],
                 exp_n[k], 8'(8'h10 + k));
      end
    end
    tests_run++;
    if (rd !== 48'd320) begin
      tests_failed++;
      $display("[TB] FAIL wrap_result: got %0d expected 320", rd);
    end
  endtask

  task automatic test_zero_len();
    int dc, nd, nr, bc;
    logic [47:0] rd, r1, rl;
    run_dot(0, 8'h00, 8'h00, 1, 4, dc, nd, nr, bc, rd, r1, rl);
    tests_run++;
    if (dc !== 1 || nd !== 1 || bc !== 1) begin
      tests_failed++;
      $display("[TB] FAIL zero_len_timing: done_cycle=%0d dones=%0d busy=%0d expected 1 1 1", dc, nd, bc);
    end
    tests_run++;
    if (nr !== 0 || rd !== 48'h0) begin
      tests_failed++;
      $display("[TB] FAIL zero_len_result: reads=%0d result=%h expected 0 0", nr, rd);
    end
  endtask

  task automatic test_start_held();
    int dc, nd, nr, bc;
    logic [47:0] rd, r1, rl;
    run_dot(3, 8'h20, 8'h20, 9, 14, dc, nd, nr, bc, rd, r1, rl);
    tests_run++;
    if (nd !== 1 || nr !== 3 || dc !== 8) begin
      tests_failed++;
      $display("[TB] FAIL start_held: dones=%0d reads=%0d done_cycle=%0d expected 1 3 8", nd, nr, dc);
    end
    tests_run++;
    if (rd !== 48'hFFFF_FFFF_FDC0) begin
      tests_failed++;
      $display("[TB] FAIL start_held_result: got %h expected FFFFFFFFFDC0", rd);
    end
  endtask

  task automatic test_back_to_back();
    int dc, nd, nr, bc;
    logic [47:0] rd, r1, rl;
    fill(1'b0, 8'h00, 16'h0001);
    run_dot(1, 8'h00, 8'h00, 1, 7, dc, nd, nr, bc, rd, r1, rl);
    tests_run++;
    if (dc !== 6 || rl !== 48'd32) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: done_cycle=%0d held=%h expected 6 20", dc, rl);
    end
    run_dot(2, 8'h20, 8'h20, 1, 9, dc, nd, nr, bc, rd, r1, rl);
    tests_run++;
    if (r1 !== 48'h0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_clear: got %h expected 0", r1);
    end
    tests_run++;
    if (dc !== 7 || rd !== 48'hFFFF_FFFF_FE80) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: got %h at cycle %0d expected FFFFFFFFFE80 at 7", rd, dc);
    end
  endtask

  task automatic test_reset_mid_run();
    int dc, nd, nr, bc;
    int late_done;
    logic [47:0] rd, r1, rl;
    start       = 1'b1;
    vec_len     = 8'd6;
    neuron_base = 8'h40;
    weight_base = 8'h80;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || sram_rd_en !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_ctrl: busy=%b rd_en=%b done=%b expected 0 0 0", busy, sram_rd_en, done);
    end
    tests_run++;
    if (result !== 48'h0 || mult_neuron !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_data: result=%h operands_zero=%b expected 0 1", result,
               (mult_neuron == '0));
    end
    late_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) late_done++;
    end
    tests_run++;
    if (late_done !== 0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_quiet: got %0d active cycles expected 0", late_done);
    end
    run_dot(1, 8'h00, 8'h00, 1, 8, dc, nd, nr, bc, rd, r1, rl);
    tests_run++;
    if (rd !== 48'd32 || dc !== 6) begin
      tests_failed++;
      $display("[TB] FAIL midrst_rerun: got %h at cycle %0d expected 20 at 6", rd, dc);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    start        = 1'b0;
    vec_len      = '0;
    neuron_base  = '0;
    weight_base  = '0;
    neuron_rdata = '0;
    weight_rdata = '0;
    for (int a = 0; a < 256; a++) begin
      nmem[a] = '0;
      wmem[a] = '0;
    end
    test_reset();
    test_single_chunk();
    test_lane_sum();
    test_signed_multi();
    test_extreme();
    test_addr_wrap();
    test_zero_len();
    test_start_held();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
